mxv_shift_sequencer: RTL and testbench

Sequences the right-shift registers of the MxV datapath for one matrix row (row · vector). For each of N_ELEMS operand words it pulses a parallel load, then drives exactly WORD_LENGTH shift cycles, so the serial bit stream feeds the bit-serial multiply-accumulate. It tags each bit with its element and bit index for the MAC, honours a downstream stall, and reports completion with a start/busy/done handshake.

---
 rtl/mxv_shift_sequencer.sv | 131 +++++++++++++
 tb/tb_mxv_shift_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxv_shift_sequencer.sv
// mxv_shift_sequencer: steps the MxV operand shift registers through one row.
// Latency: load in the cycle after start; done at N_ELEMS*(1+WORD_LENGTH)+1 cycles.
// Backpressure: stall freezes SHIFT (counters, state, shift/first/last); LOAD is never stalled.
//
// Ports:
//   clk, reset (async, active-low), sys_reset (sync clear, active-high)
//   start      - row request, honoured only in IDLE
//   stall      - downstream not ready; gates shift combinationally
//   load/shift - parallel-load and shift-enable strobes, mutually exclusive
//   elem_index - operand word being worked on; bit_index - bit about to shift out
//   acc_clear  - MAC accumulator clear, with the first word's load
//   first_bit/last_bit - qualify shift at bit 0 / bit WORD_LENGTH-1
//   busy/done  - row in progress / one-cycle completion pulse
module mxv_shift_sequencer #(
  parameter int WORD_LENGTH = 8,
  parameter int N_ELEMS     = 4,
  parameter int IDX_WIDTH   = 2,
  parameter int BIT_WIDTH   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sys_reset,
  input  logic                 start,
  input  logic                 stall,
  output logic                 load,
  output logic                 shift,
  output logic [IDX_WIDTH-1:0] elem_index,
  output logic [BIT_WIDTH-1:0] bit_index,
  output logic                 acc_clear,
  output logic                 first_bit,
  output logic                 last_bit,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [BIT_WIDTH-1:0] LAST_BIT  = BIT_WIDTH'(WORD_LENGTH - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_ELEM = IDX_WIDTH'(N_ELEMS - 1);

  state_t               state;
  logic [IDX_WIDTH-1:0] elem_cnt;
  logic [BIT_WIDTH-1:0] bit_cnt;
  // Registered "in SHIFT" flag; the actual shift strobe is this gated by stall.
  logic                 shift_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      elem_cnt    <= '0;
      bit_cnt     <= '0;
      shift_phase <= 1'b0;
      load        <= 1'b0;
      acc_clear   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (sys_reset) begin
      state       <= IDLE;
      elem_cnt    <= '0;
      bit_cnt     <= '0;
      shift_phase <= 1'b0;
      load        <= 1'b0;
      acc_clear   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            elem_cnt  <= '0;
            bit_cnt   <= '0;
            load      <= 1'b1;
            acc_clear <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          state       <= SHIFT;
          bit_cnt     <= '0;
          load        <= 1'b0;
          acc_clear   <= 1'b0;
          shift_phase <= 1'b1;
        end
        SHIFT: begin
          if (!stall) begin
            if (bit_cnt != LAST_BIT) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (elem_cnt == LAST_ELEM) begin
              // Row finished; elem_cnt is kept so DONE still shows the last word.
              state       <= DONE;
              bit_cnt     <= '0;
              shift_phase <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              state       <= LOAD;
              elem_cnt    <= elem_cnt + 1'b1;
              bit_cnt     <= '0;
              shift_phase <= 1'b0;
              load        <= 1'b1;
            end
          end
        end
        DONE: begin
          // start is deliberately not looked at here; it must be seen in IDLE.
          state    <= IDLE;
          elem_cnt <= '0;
          done     <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          elem_cnt    <= '0;
          bit_cnt     <= '0;
          shift_phase <= 1'b0;
          load        <= 1'b0;
          acc_clear   <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

  assign shift      = shift_phase & ~stall;
  assign first_bit  = shift & (bit_cnt == '0);
  assign last_bit   = shift & (bit_cnt == LAST_BIT);
  assign elem_index = elem_cnt;
  assign bit_index  = bit_cnt;

endmodule

// File: tb/tb_mxv_shift_sequencer.sv
// Bench for mxv_shift_sequencer: default-parameter instance driven by a row
// model with random and directed stall patterns, plus a 1-element/1-bit
// instance driven from a vector table.
module tb_mxv_shift_sequencer;
  localparam int WL = 8;
  localparam int NE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sys_reset, start, stall;
  logic load, shift, acc_clear, first_bit, last_bit, busy, done;
  logic [1:0] elem_index;
  logic [2:0] bit_index;

  logic s_sys_reset, s_start, s_stall;
  logic s_load, s_shift, s_acc_clear, s_first_bit, s_last_bit, s_busy, s_done;
  logic [0:0] s_elem_index;
  logic [0:0] s_bit_index;

  mxv_shift_sequencer #(.WORD_LENGTH(WL), .N_ELEMS(NE), .IDX_WIDTH(2), .BIT_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .sys_reset(sys_reset), .start(start), .stall(stall),
    .load(load), .shift(shift), .elem_index(elem_index), .bit_index(bit_index),
    .acc_clear(acc_clear), .first_bit(first_bit), .last_bit(last_bit),
    .busy(busy), .done(done)
  );

  mxv_shift_sequencer #(.WORD_LENGTH(1), .N_ELEMS(1), .IDX_WIDTH(1), .BIT_WIDTH(1)) dut_small (
    .clk(clk), .reset(reset), .sys_reset(s_sys_reset), .start(s_start), .stall(s_stall),
    .load(s_load), .shift(s_shift), .elem_index(s_elem_index), .bit_index(s_bit_index),
    .acc_clear(s_acc_clear), .first_bit(s_first_bit), .last_bit(s_last_bit),
    .busy(s_busy), .done(s_done)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs for one cycle. fl = {load,shift,acc_clear,first,last,busy,done}.
  typedef struct {
    logic [6:0] fl;
    int         elem;
    int         bidx;
    bit         cb;     // bit_index is compared only when set
  } exp_t;

  typedef struct {
    logic       start;
    logic       stall;
    logic       sys_reset;
    logic [6:0] fl;
    int         elem;
    int         bidx;
    bit         cb;
  } vec_t;

  exp_t expq[$];
  bit   stl[0:511];

  task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [22:0] act_big(input bit cb);
    logic [7:0] b;
    b = cb ? 8'(bit_index) : 8'd0;
    return {load, shift, acc_clear, first_bit, last_bit, busy, done, 8'(elem_index), b};
  endfunction

  function automatic logic [22:0] act_small(input bit cb);
    logic [7:0] b;
    b = cb ? 8'(s_bit_index) : 8'd0;
    return {s_load, s_shift, s_acc_clear, s_first_bit, s_last_bit, s_busy, s_done,
            8'(s_elem_index), b};
  endfunction

  function automatic logic [22:0] exp_pack(input logic [6:0] fl, input int elem, input int bidx,
                                           input bit cb);
    return {fl, 8'(elem), cb ? 8'(bidx) : 8'd0};
  endfunction

  function automatic exp_t mk(input bit ld, input bit sh, input bit ac, input bit fb, input bit lb,
                              input bit bz, input bit dn, input int e, input int b, input bit cb);
    exp_t r;
    r.fl   = {ld, sh, ac, fb, lb, bz, dn};
    r.elem = e;
    r.bidx = b;
    r.cb   = cb;
    return r;
  endfunction

  // Row model: each word is one load cycle followed by WL shift cycles, where
  // a stalled cycle repeats the same bit; then one done cycle and idle.
  // expq[i] is the expectation for cycle i+1 after the start edge.
  task automatic build_model();
    int c;
    int b;
    expq.delete();
    c = 1;
    for (int e = 0; e < NE; e++) begin
      expq.push_back(mk(1, 0, e == 0, 0, 0, 1, 0, e, 0, 1));
      c++;
      b = 0;
      while (b < WL) begin
        if (stl[c]) expq.push_back(mk(0, 0, 0, 0, 0, 1, 0, e, b, 1));
        else begin
          expq.push_back(mk(0, 1, 0, b == 0, b == WL - 1, 1, 0, e, b, 1));
          b++;
        end
        c++;
      end
    end
    expq.push_back(mk(0, 0, 0, 0, 0, 0, 1, NE - 1, 0, 0));
    expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  // Called between edges with the DUT idle; returns there in the idle cycle.
  task automatic run_row(input string tag, output int done_cyc, output int nshift);
    done_cyc = -1;
    nshift   = 0;
    build_model();
    start = 1'b1;
    for (int i = 0; i < expq.size(); i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stall = stl[i + 1];
      #1;
      chk($sformatf("%s_c%0d", tag, i + 1), act_big(expq[i].cb),
          exp_pack(expq[i].fl, expq[i].elem, expq[i].bidx, expq[i].cb));
      if (done && done_cyc < 0) done_cyc = i + 1;
      if (shift) nshift++;
    end
    stall = 1'b0;
  endtask

  task automatic clear_stl();
    foreach (stl[i]) stl[i] = 1'b0;
  endtask

  vec_t vt[16];
  int   dc, ns, bad, first_load_after, loads_before_done;

  initial begin
    // Small instance vectors: inputs applied, outputs checked, then one edge.
    vt[0]  = '{1, 0, 0, 7'b0000000, 0, 0, 1};
    vt[1]  = '{0, 1, 0, 7'b1010010, 0, 0, 1};  // load ignores stall
    vt[2]  = '{0, 1, 0, 7'b0000010, 0, 0, 1};  // stalled shift
    vt[3]  = '{0, 0, 0, 7'b0101110, 0, 0, 1};  // shift with first and last
    vt[4]  = '{0, 0, 0, 7'b0000001, 0, 0, 0};  // done
    vt[5]  = '{1, 0, 0, 7'b0000000, 0, 0, 1};
    vt[6]  = '{0, 0, 1, 7'b1010010, 0, 0, 1};  // sys_reset during load
    vt[7]  = '{0, 0, 0, 7'b0000000, 0, 0, 1};
    vt[8]  = '{1, 0, 1, 7'b0000000, 0, 0, 1};  // sys_reset beats start
    vt[9]  = '{0, 0, 0, 7'b0000000, 0, 0, 1};
    vt[10] = '{1, 0, 0, 7'b0000000, 0, 0, 1};
    vt[11] = '{0, 0, 0, 7'b1010010, 0, 0, 1};
    vt[12] = '{0, 0, 0, 7'b0101110, 0, 0, 1};
    vt[13] = '{1, 0, 0, 7'b0000001, 0, 0, 0};  // start in done is ignored
    vt[14] = '{0, 0, 0, 7'b0000000, 0, 0, 1};
    vt[15] = '{0, 0, 0, 7'b0000000, 0, 0, 1};

    reset = 1'b0; sys_reset = 1'b0; start = 1'b0; stall = 1'b0;
    s_sys_reset = 1'b0; s_start = 1'b0; s_stall = 1'b0;
    clear_stl();

    #2;
    chk("reset_low", act_big(1), '0);
    chk("reset_low_small", act_small(1), '0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    chk("reset_release", act_big(1), '0);

    for (int i = 0; i < 16; i++) begin
      s_start = vt[i].start; s_stall = vt[i].stall; s_sys_reset = vt[i].sys_reset;
      #1;
      chk($sformatf("small_v%0d", i), act_small(vt[i].cb),
          exp_pack(vt[i].fl, vt[i].elem, vt[i].bidx, vt[i].cb));
      @(posedge clk); #2;
    end
    s_start = 1'b0; s_stall = 1'b0; s_sys_reset = 1'b0;

    // Unstalled row.
    clear_stl();
    run_row("row_nostall", dc, ns);
    chk("nostall_done_cycle", 23'(dc), 23'd37);
    chk("nostall_shift_count", 23'(ns), 23'd32);

    // Three stall cycles on element 1, bit 4 (that bit would shift in cycle 15).
    clear_stl();
    stl[15] = 1'b1; stl[16] = 1'b1; stl[17] = 1'b1;
    run_row("row_stall", dc, ns);
    chk("stall_done_cycle", 23'(dc), 23'd40);
    chk("stall_shift_count", 23'(ns), 23'd32);

    // Random stall rows.
    for (int r = 0; r < 8; r++) begin
      clear_stl();
      for (int c = 1; c < 200; c++) stl[c] = ($urandom_range(0, 9) < 3);
      run_row($sformatf("rand%0d", r), dc, ns);
      chk($sformatf("rand%0d_shift_count", r), 23'(ns), 23'd32);
    end

    // start held high: the next load comes two cycles after done.
    clear_stl();
    start = 1'b1;
    dc = -1; first_load_after = -1; loads_before_done = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #2;
      if (load && dc < 0) loads_before_done++;
      if (done && dc < 0) dc = c;
      if (load && dc > 0 && first_load_after < 0) first_load_after = c;
    end
    chk("held_done_cycle", 23'(dc), 23'd37);
    chk("held_loads_in_row", 23'(loads_before_done), 23'd4);
    chk("held_next_load", 23'(first_load_after), 23'd39);
    start = 1'b0;
    sys_reset = 1'b1;
    @(posedge clk); #2;
    sys_reset = 1'b0;
    chk("sysreset_flush", act_big(1), '0);

    // sys_reset in element 2's shift phase aborts the row silently.
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      if (c == 22) begin
        chk("abort_pre_state", {21'd0, shift, busy}, 23'd3);
        chk("abort_pre_elem", 23'(elem_index), 23'd2);
        sys_reset = 1'b1;
      end
    end
    @(posedge clk); #1;
    sys_reset = 1'b0;
    #1;
    chk("abort_idle", act_big(1), '0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (done || busy || load) bad++;
    end
    chk("abort_no_done", 23'(bad), 23'd0);
    clear_stl();
    run_row("restart", dc, ns);
    chk("restart_done_cycle", 23'(dc), 23'd37);

    // Asynchronous reset mid-row, asserted between edges.
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #2;
      start = 1'b0;
    end
    #1 reset = 1'b0;
    #1;
    chk("async_reset_immediate", act_big(1), '0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #2;
      if (act_big(1) != '0) bad++;
    end
    chk("async_reset_stays_idle", 23'(bad), 23'd0);
    run_row("post_reset", dc, ns);
    chk("post_reset_shift_count", 23'(ns), 23'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
